sparse_chunk_writer: RTL and testbench

Upstream feeder for the compute unit's filter/IFM chunk buffers. Accepts dense byte beats over a valid/ready stream and compresses each beat into a sparsemap plus left-packed nonzero bytes. Drives the chunk write port (`wr_valid`/`wr_count`/`wr_sel`) into a ping-pong pair of chunk banks and tracks bank occupancy. Hands completed chunks to the consumer through `chunk_rd_sel_o`, `chunk_rdy_o` and `rd_done_i`.

---
 rtl/sparse_chunk_writer_if.sv | 42 ++++
 rtl/sparse_chunk_writer.sv | 109 ++++++++++
 tb/tb_sparse_chunk_writer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/sparse_chunk_writer_if.sv
// Stream-in, chunk-write and chunk-handoff signals of sparse_chunk_writer.
// chunk_nnz_o is present only when CHUNK_NNZ_EN is defined.
interface sparse_chunk_writer_if #(
  parameter int BUS_SIZE       = 32,
  parameter int WR_DAT_CYC_NUM = 4
);
  localparam int CNT_W = (WR_DAT_CYC_NUM > 1) ? $clog2(WR_DAT_CYC_NUM) : 1;
  localparam int NNZ_W = $clog2(BUS_SIZE*WR_DAT_CYC_NUM) + 1;

  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [BUS_SIZE*8-1:0] in_data_i;
  logic                  chunk_wr_valid_o;
  logic [CNT_W-1:0]      chunk_wr_count_o;
  logic                  chunk_wr_sel_o;
  logic [BUS_SIZE-1:0]   sparsemap_o;
  logic [BUS_SIZE*8-1:0] nonzero_data_o;
  logic                  chunk_rd_sel_o;
  logic                  chunk_rdy_o;
  logic                  rd_done_i;
`ifdef CHUNK_NNZ_EN
  logic [NNZ_W-1:0]      chunk_nnz_o;
`endif

  modport slave (
    input  in_valid_i, in_data_i, rd_done_i,
    output in_ready_o, chunk_wr_valid_o, chunk_wr_count_o, chunk_wr_sel_o,
           sparsemap_o, nonzero_data_o, chunk_rd_sel_o, chunk_rdy_o
`ifdef CHUNK_NNZ_EN
           , chunk_nnz_o
`endif
  );

  modport master (
    output in_valid_i, in_data_i, rd_done_i,
    input  in_ready_o, chunk_wr_valid_o, chunk_wr_count_o, chunk_wr_sel_o,
           sparsemap_o, nonzero_data_o, chunk_rd_sel_o, chunk_rdy_o
`ifdef CHUNK_NNZ_EN
           , chunk_nnz_o
`endif
  );
endinterface

// File: rtl/sparse_chunk_writer.sv
// Dense beat -> sparsemap + left-packed nonzero bytes, written into a ping-pong chunk bank pair.
// Optional CHUNK_NNZ_EN adds per-bank nonzero byte counters reported on chunk_nnz_o.
module sparse_chunk_writer #(
  parameter int BUS_SIZE       = 32,
  parameter int WR_DAT_CYC_NUM = 4
) (
  input logic clk_i,
  input logic rst_i,
  sparse_chunk_writer_if.slave bus
);
  localparam int CNT_W = (WR_DAT_CYC_NUM > 1) ? $clog2(WR_DAT_CYC_NUM) : 1;
  localparam int IDX_W = $clog2(BUS_SIZE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WR_DAT_CYC_NUM-1);

  logic [BUS_SIZE-1:0][7:0]      din, packed_data;
  logic [BUS_SIZE-1:0]           nz;
  logic [BUS_SIZE-1:0][IDX_W-1:0] pos;

  assign din = bus.in_data_i;

  // pos[i] = number of nonzero lanes below lane i = packed destination of lane i
  assign pos[0] = '0;
  genvar i;
  for (i = 0; i < BUS_SIZE; i++) begin : g_lane
    assign nz[i] = |din[i];
    if (i > 0) begin : g_pfx
      assign pos[i] = pos[i-1] + IDX_W'(nz[i-1]);
    end
  end

  always_comb begin
    packed_data = '0;
    for (int l = 0; l < BUS_SIZE; l++)
      if (nz[l]) packed_data[pos[l]] = din[l];
  end

  logic                acc_sel, rd_sel;
  logic [CNT_W-1:0]    acc_cnt;
  logic [1:0]          busy, full;
  logic                wr_valid, wr_sel;
  logic [CNT_W-1:0]    wr_count;
  logic [BUS_SIZE-1:0] smap;
  logic [BUS_SIZE-1:0][7:0] nzdat;

  logic accept, rd_fire, last_wr;
  assign bus.in_ready_o = !busy[acc_sel] | (acc_cnt != '0);
  assign accept  = bus.in_valid_i & bus.in_ready_o;
  assign rd_fire = bus.rd_done_i & full[rd_sel];
  assign last_wr = wr_valid & (wr_count == LAST);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      acc_sel  <= 1'b0;
      acc_cnt  <= '0;
      rd_sel   <= 1'b0;
      busy     <= '0;
      full     <= '0;
      wr_valid <= 1'b0;
      wr_sel   <= 1'b0;
      wr_count <= '0;
      smap     <= '0;
      nzdat    <= '0;
    end else begin
      wr_valid <= accept;
      if (accept) begin
        wr_count <= acc_cnt;
        wr_sel   <= acc_sel;
        smap     <= nz;
        nzdat    <= packed_data;
        if (acc_cnt == LAST) begin
          acc_cnt <= '0;
          acc_sel <= ~acc_sel;
        end else begin
          acc_cnt <= acc_cnt + 1'b1;
        end
        if (acc_cnt == '0) busy[acc_sel] <= 1'b1;
      end
      // a freed bank is never the one being started or completed this edge
      if (rd_fire) begin
        busy[rd_sel] <= 1'b0;
        full[rd_sel] <= 1'b0;
        rd_sel       <= ~rd_sel;
      end
      if (last_wr) full[wr_sel] <= 1'b1;
    end
  end

  assign bus.chunk_wr_valid_o = wr_valid;
  assign bus.chunk_wr_count_o = wr_count;
  assign bus.chunk_wr_sel_o   = wr_sel;
  assign bus.sparsemap_o      = smap;
  assign bus.nonzero_data_o   = nzdat;
  assign bus.chunk_rd_sel_o   = rd_sel;
  assign bus.chunk_rdy_o      = full[rd_sel];

`ifdef CHUNK_NNZ_EN
  localparam int NNZ_W = $clog2(BUS_SIZE*WR_DAT_CYC_NUM) + 1;
  logic [1:0][NNZ_W-1:0] nnz;
  logic [NNZ_W-1:0]      popcnt;
  assign popcnt = NNZ_W'(pos[BUS_SIZE-1]) + NNZ_W'(nz[BUS_SIZE-1]);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) nnz <= '0;
    else if (accept && !full[acc_sel])
      nnz[acc_sel] <= ((acc_cnt == '0) ? '0 : nnz[acc_sel]) + popcnt;
  end
  assign bus.chunk_nnz_o = nnz[rd_sel];
`endif
endmodule

// File: tb/tb_sparse_chunk_writer.sv
// Directed bench for sparse_chunk_writer; nnz checks only when CHUNK_NNZ_EN is defined.
module tb_sparse_chunk_writer;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  sparse_chunk_writer_if sif ();
  sparse_chunk_writer dut (.clk_i(clk), .rst_i(rst_n), .bus(sif));

  int checks = 0, errors = 0;
  logic [255:0] ramp, ramp_pk, pat;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".ready"}, 256'(sif.in_ready_o), 256'd1);
    chk({tag, ".wr_valid"}, 256'(sif.chunk_wr_valid_o), 256'd0);
    chk({tag, ".wr_count"}, 256'(sif.chunk_wr_count_o), 256'd0);
    chk({tag, ".wr_sel"}, 256'(sif.chunk_wr_sel_o), 256'd0);
    chk({tag, ".smap"}, 256'(sif.sparsemap_o), 256'd0);
    chk({tag, ".nzdat"}, 256'(sif.nonzero_data_o), 256'd0);
    chk({tag, ".rd_sel"}, 256'(sif.chunk_rd_sel_o), 256'd0);
    chk({tag, ".rdy"}, 256'(sif.chunk_rdy_o), 256'd0);
`ifdef CHUNK_NNZ_EN
    chk({tag, ".nnz"}, 256'(sif.chunk_nnz_o), 256'd0);
`endif
  endtask

  task automatic rd_pulse();
    sif.rd_done_i = 1'b1;
    step();
    sif.rd_done_i = 1'b0;
  endtask

  initial begin
    for (int b = 0; b < 32; b++) begin
      ramp[b*8 +: 8]    = 8'(b);
      ramp_pk[b*8 +: 8] = (b < 31) ? 8'(b+1) : 8'd0;
    end
    pat = '0;
    pat[47:40]   = 8'hAA;
    pat[167:160] = 8'h55;
    sif.in_valid_i = 1'b0;
    sif.in_data_i  = '0;
    sif.rd_done_i  = 1'b0;

    step(); step();
    chk_reset("rst");
    rst_n = 1'b1;
    step();

    // ramp chunk into bank 0
    sif.in_data_i = ramp; sif.in_valid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("ramp.valid", 256'(sif.chunk_wr_valid_o), 256'd1);
      chk("ramp.count", 256'(sif.chunk_wr_count_o), 256'(k));
      chk("ramp.sel", 256'(sif.chunk_wr_sel_o), 256'd0);
      chk("ramp.smap", 256'(sif.sparsemap_o), 256'hFFFF_FFFE);
      chk("ramp.nzdat", 256'(sif.nonzero_data_o), ramp_pk);
    end
    chk("ramp.rdy_early", 256'(sif.chunk_rdy_o), 256'd0);
    sif.in_valid_i = 1'b0;
    step();
    chk("ramp.rdy", 256'(sif.chunk_rdy_o), 256'd1);
    chk("ramp.wr_idle", 256'(sif.chunk_wr_valid_o), 256'd0);
`ifdef CHUNK_NNZ_EN
    chk("ramp.nnz", 256'(sif.chunk_nnz_o), 256'd124);
`endif
    rd_pulse();
    chk("ramp.rd_sel", 256'(sif.chunk_rd_sel_o), 256'd1);
    chk("ramp.rdy_clr", 256'(sif.chunk_rdy_o), 256'd0);

    // all-zero chunk into bank 1
    sif.in_data_i = '0; sif.in_valid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("zero.count", 256'(sif.chunk_wr_count_o), 256'(k));
      chk("zero.sel", 256'(sif.chunk_wr_sel_o), 256'd1);
      chk("zero.smap", 256'(sif.sparsemap_o), 256'd0);
      chk("zero.nzdat", 256'(sif.nonzero_data_o), 256'd0);
    end
    sif.in_valid_i = 1'b0;
    step();
    chk("zero.rdy", 256'(sif.chunk_rdy_o), 256'd1);
`ifdef CHUNK_NNZ_EN
    chk("zero.nnz", 256'(sif.chunk_nnz_o), 256'd0);
`endif
    rd_pulse();
    chk("zero.rd_sel", 256'(sif.chunk_rd_sel_o), 256'd0);

    // rd_done with nothing ready is ignored
    rd_pulse();
    chk("ign.rd_sel", 256'(sif.chunk_rd_sel_o), 256'd0);
    chk("ign.rdy", 256'(sif.chunk_rdy_o), 256'd0);
    chk("ign.ready", 256'(sif.in_ready_o), 256'd1);

    // three chunks back to back, third stalls
    sif.in_data_i = pat; sif.in_valid_i = 1'b1;
    for (int c = 0; c < 2; c++)
      for (int k = 0; k < 4; k++) begin
        step();
        chk("b2b.count", 256'(sif.chunk_wr_count_o), 256'(k));
        chk("b2b.sel", 256'(sif.chunk_wr_sel_o), 256'(c));
      end
    chk("b2b.smap", 256'(sif.sparsemap_o), 256'h0010_0020);
    chk("b2b.nzdat", 256'(sif.nonzero_data_o), 256'h55AA);
    chk("stall.ready", 256'(sif.in_ready_o), 256'd0);
    step();
    chk("stall.wr_valid", 256'(sif.chunk_wr_valid_o), 256'd0);
    chk("stall.rdy", 256'(sif.chunk_rdy_o), 256'd1);
    step();
    chk("stall.ready2", 256'(sif.in_ready_o), 256'd0);
    rd_pulse();
    chk("free.ready", 256'(sif.in_ready_o), 256'd1);
    chk("free.wr_valid", 256'(sif.chunk_wr_valid_o), 256'd0);
    chk("free.rd_sel", 256'(sif.chunk_rd_sel_o), 256'd1);
    chk("free.rdy1", 256'(sif.chunk_rdy_o), 256'd1);
`ifdef CHUNK_NNZ_EN
    chk("free.nnz1", 256'(sif.chunk_nnz_o), 256'd8);
`endif
    for (int k = 0; k < 4; k++) begin
      step();
      chk("c2.count", 256'(sif.chunk_wr_count_o), 256'(k));
      chk("c2.sel", 256'(sif.chunk_wr_sel_o), 256'd0);
    end
    sif.in_valid_i = 1'b0;
    step();
    rd_pulse();
    chk("c2.rd_sel", 256'(sif.chunk_rd_sel_o), 256'd0);
    chk("c2.rdy", 256'(sif.chunk_rdy_o), 256'd1);
`ifdef CHUNK_NNZ_EN
    chk("c2.nnz", 256'(sif.chunk_nnz_o), 256'd8);
`endif
    rd_pulse();
    chk("c2.rd_sel2", 256'(sif.chunk_rd_sel_o), 256'd1);
    chk("c2.rdy_clr", 256'(sif.chunk_rdy_o), 256'd0);

    // in_valid toggling every other cycle into bank 1
    for (int k = 0; k < 4; k++) begin
      sif.in_valid_i = 1'b1;
      step();
      chk("tog.valid", 256'(sif.chunk_wr_valid_o), 256'd1);
      chk("tog.count", 256'(sif.chunk_wr_count_o), 256'(k));
      chk("tog.sel", 256'(sif.chunk_wr_sel_o), 256'd1);
      sif.in_valid_i = 1'b0;
      step();
      chk("tog.gap", 256'(sif.chunk_wr_valid_o), 256'd0);
    end
    chk("tog.rdy", 256'(sif.chunk_rdy_o), 256'd1);
    rd_pulse();
    chk("tog.rd_sel", 256'(sif.chunk_rd_sel_o), 256'd0);

    // reset after two beats discards the partial chunk
    sif.in_valid_i = 1'b1;
    step(); step();
    chk("mid.count", 256'(sif.chunk_wr_count_o), 256'd1);
    sif.in_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset("mid_rst");
    step();
    chk("mid_rst.no_strobe", 256'(sif.chunk_wr_valid_o), 256'd0);
    rst_n = 1'b1;
    step();
    sif.in_valid_i = 1'b1;
    step();
    chk("post.valid", 256'(sif.chunk_wr_valid_o), 256'd1);
    chk("post.count", 256'(sif.chunk_wr_count_o), 256'd0);
    chk("post.sel", 256'(sif.chunk_wr_sel_o), 256'd0);
    sif.in_valid_i = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
